// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: sync, blank, coordinates and frame_start, all registered.
// Define VGA_TIMING_PATTERN_EN to add the registered 8-bar colour pattern outputs (pattern_red/green/blue).
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CNT_W      = 10
) (
  input  logic             pixel_clock,
  input  logic             reset,
  output logic             h_synch,
  output logic             v_synch,
  output logic             blank,
  output logic [CNT_W-1:0] pixel_count,
  output logic [CNT_W-1:0] line_count,
  output logic             frame_start
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic             pattern_red,
  output logic             pattern_green,
  output logic             pattern_blue
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic H_ASSERT = 1'(H_SYNC_POL);
  localparam logic V_ASSERT = 1'(V_SYNC_POL);

  function automatic logic sync_level(input logic in_pulse, input logic pol);
    return in_pulse ? pol : ~pol;
  endfunction

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // Stage p0: raster counters
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  logic active_p0;
  logic h_pulse_p0;
  logic v_pulse_p0;
  logic origin_p0;

  always_comb begin
    active_p0  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    h_pulse_p0 = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    v_pulse_p0 = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    origin_p0  = (h_cnt == '0) && (v_cnt == '0);
  end

  // Stage p1: every output registered from the same counter snapshot, so they never skew
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      pixel_count <= '0;
      line_count  <= '0;
      blank       <= 1'b1;
      h_synch     <= ~H_ASSERT;
      v_synch     <= ~V_ASSERT;
      frame_start <= 1'b0;
    end else begin
      pixel_count <= h_cnt;
      line_count  <= v_cnt;
      blank       <= ~active_p0;
      h_synch     <= sync_level(h_pulse_p0, H_ASSERT);
      v_synch     <= sync_level(v_pulse_p0, V_ASSERT);
      frame_start <= origin_p0;
    end
  end

`ifdef VGA_TIMING_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

  function automatic logic [2:0] bar_color(input logic [CNT_W-1:0] h);
    return 3'(h / BAR_W);
  endfunction

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      {pattern_red, pattern_green, pattern_blue} <= 3'b000;
    end else begin
      {pattern_red, pattern_green, pattern_blue} <= active_p0 ? bar_color(h_cnt) : 3'b000;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing for line-level checks, plus a tiny raster
// (16x9, H_SYNC_POL=1) for frame-level checks within a short run.
module tb_vga_timing_gen;

  logic pixel_clock = 1'b0;
  logic reset = 1'b1;
  logic reset_small = 1'b1;

  always #20 pixel_clock = ~pixel_clock;

  logic       h_synch, v_synch, blank, frame_start;
  logic [9:0] pixel_count, line_count;
  logic       hs_s, vs_s, blank_s, fs_s;
  logic [9:0] pc_s, lc_s;
`ifdef VGA_TIMING_PATTERN_EN
  logic r, g, b, r_s, g_s, b_s;
`endif

  vga_timing_gen dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .h_synch     (h_synch),
    .v_synch     (v_synch),
    .blank       (blank),
    .pixel_count (pixel_count),
    .line_count  (line_count),
    .frame_start (frame_start)
`ifdef VGA_TIMING_PATTERN_EN
    ,
    .pattern_red   (r),
    .pattern_green (g),
    .pattern_blue  (b)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_SYNC_POL(1), .V_SYNC_POL(0), .CNT_W(10)
  ) dut_s (
    .pixel_clock (pixel_clock),
    .reset       (reset_small),
    .h_synch     (hs_s),
    .v_synch     (vs_s),
    .blank       (blank_s),
    .pixel_count (pc_s),
    .line_count  (lc_s),
    .frame_start (fs_s)
`ifdef VGA_TIMING_PATTERN_EN
    ,
    .pattern_red   (r_s),
    .pattern_green (g_s),
    .pattern_blue  (b_s)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One posedge, then sample on the following negedge.
  task automatic tick();
    @(negedge pixel_clock);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, hs_first, hs_bad, blank_hi, blank_bad, pix_bad, guard;
    int pos_bad, fs_cnt, fs_idx2, vs_low, vs_first, vs_bad, wrap_good;
    int eh, ev;
    int prev_h, prev_v;
    logic [2:0] rgb0, rgb80, rgb639, rgb700;

    // Default instance: reset state and first pixel
    repeat (5) @(posedge pixel_clock);
    @(negedge pixel_clock);
    check("rst_pixel", int'(pixel_count), 0);
    check("rst_line", int'(line_count), 0);
    check("rst_blank", int'(blank), 1);
    check("rst_fs", int'(frame_start), 0);
    check("rst_hs", int'(h_synch), 1);
    check("rst_vs", int'(v_synch), 1);
    reset = 1'b0;
    tick();
    check("first_pixel", int'(pixel_count), 0);
    check("first_line", int'(line_count), 0);
    check("first_blank", int'(blank), 0);
    check("first_fs", int'(frame_start), 1);
    check("first_hs", int'(h_synch), 1);
    check("first_vs", int'(v_synch), 1);

    // One full line
    hs_low = 0; hs_first = -1; hs_bad = 0; blank_hi = 0; blank_bad = 0; pix_bad = 0;
    rgb0 = 3'b111; rgb80 = 3'b000; rgb639 = 3'b000; rgb700 = 3'b111;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick();
      if (int'(pixel_count) != i || line_count != 10'd0) pix_bad++;
      if (!h_synch) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(pixel_count);
      end
      if ((!h_synch) != (pixel_count >= 10'd656 && pixel_count < 10'd752)) hs_bad++;
      if (blank) blank_hi++;
      if (blank != (pixel_count >= 10'd640)) blank_bad++;
      if (i > 0 && frame_start) pix_bad++;
`ifdef VGA_TIMING_PATTERN_EN
      if (i == 0)   rgb0   = {r, g, b};
      if (i == 80)  rgb80  = {r, g, b};
      if (i == 639) rgb639 = {r, g, b};
      if (i == 700) rgb700 = {r, g, b};
`endif
    end
    check("line_coords", pix_bad, 0);
    check("hs_low_cycles", hs_low, 96);
    check("hs_first_pixel", hs_first, 656);
    check("hs_window", hs_bad, 0);
    check("blank_cycles", blank_hi, 160);
    check("blank_window", blank_bad, 0);
`ifdef VGA_TIMING_PATTERN_EN
    check("rgb_px0", int'(rgb0), 0);
    check("rgb_px80", int'(rgb80), 1);
    check("rgb_px639", int'(rgb639), 7);
    check("rgb_px700", int'(rgb700), 0);
`endif
    tick();
    check("line_wrap_pixel", int'(pixel_count), 0);
    check("line_wrap_line", int'(line_count), 1);
    check("line_wrap_fs", int'(frame_start), 0);

    // Asynchronous reset mid-line
    guard = 0;
    while (pixel_count != 10'd300 && guard < 1000) begin
      tick();
      guard++;
    end
    check("reach_px300", int'(pixel_count), 300);
    check("px300_blank", int'(blank), 0);
    reset = 1'b1;
    #1;
    check("async_rst_pixel", int'(pixel_count), 0);
    check("async_rst_line", int'(line_count), 0);
    check("async_rst_blank", int'(blank), 1);
    check("async_rst_hs", int'(h_synch), 1);
    check("async_rst_fs", int'(frame_start), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("restart_pixel", int'(pixel_count), 0);
    check("restart_line", int'(line_count), 0);
    check("restart_fs", int'(frame_start), 1);
    tick();
    check("restart_next", int'(pixel_count), 1);

    // Small instance: reset state, then two full frames
    check("s_rst_hs", int'(hs_s), 0);
    check("s_rst_vs", int'(vs_s), 1);
    check("s_rst_blank", int'(blank_s), 1);
    reset_small = 1'b0;
    tick();
    check("s_first_fs", int'(fs_s), 1);
    check("s_first_blank", int'(blank_s), 0);
    check("s_first_hs", int'(hs_s), 0);

    pos_bad = 0; fs_cnt = 0; fs_idx2 = -1; vs_low = 0; vs_first = -1; vs_bad = 0;
    hs_bad = 0; blank_bad = 0; wrap_good = 0; prev_h = -1; prev_v = -1;
    rgb0 = 3'b111; rgb80 = 3'b000; rgb639 = 3'b000; rgb700 = 3'b111;
    for (int i = 0; i < 288; i++) begin
      if (i > 0) tick();
      eh = i % 16;
      ev = (i / 16) % 9;
      if (int'(pc_s) != eh || int'(lc_s) != ev) pos_bad++;
      if (fs_s) begin
        fs_cnt++;
        if (i > 0 && fs_idx2 < 0) fs_idx2 = i;
      end
      if (!vs_s) begin
        vs_low++;
        if (vs_first < 0) vs_first = i;
      end
      if ((!vs_s) != (ev == 5 || ev == 6)) vs_bad++;
      if (hs_s != (eh >= 10 && eh <= 12)) hs_bad++;
      if (blank_s != (eh >= 8 || ev >= 4)) blank_bad++;
      if (prev_h == 15 && prev_v == 8 && pc_s == 10'd0 && lc_s == 10'd0 && fs_s && !blank_s)
        wrap_good++;
      prev_h = int'(pc_s);
      prev_v = int'(lc_s);
`ifdef VGA_TIMING_PATTERN_EN
      if (i == 0)  rgb0   = {r_s, g_s, b_s};
      if (i == 1)  rgb80  = {r_s, g_s, b_s};
      if (i == 7)  rgb639 = {r_s, g_s, b_s};
      if (i == 12) rgb700 = {r_s, g_s, b_s};
`endif
    end
    check("s_coords", pos_bad, 0);
    check("s_fs_count", fs_cnt, 2);
    check("s_frame_period", fs_idx2, 144);
    check("s_vs_low_cycles", vs_low, 64);
    check("s_vs_first", vs_first, 80);
    check("s_vs_window", vs_bad, 0);
    check("s_hs_window", hs_bad, 0);
    check("s_blank_window", blank_bad, 0);
    check("s_wrap", wrap_good, 1);
`ifdef VGA_TIMING_PATTERN_EN
    check("s_rgb_px0", int'(rgb0), 0);
    check("s_rgb_px1", int'(rgb80), 1);
    check("s_rgb_px7", int'(rgb639), 7);
    check("s_rgb_px12", int'(rgb700), 0);
`endif
    tick();
    check("s_wrap2_pixel", int'(pc_s), 0);
    check("s_wrap2_line", int'(lc_s), 0);
    check("s_wrap2_fs", int'(fs_s), 1);

    // Small instance: asynchronous reset mid-frame at (3,2)
    guard = 0;
    while (!(pc_s == 10'd3 && lc_s == 10'd2) && guard < 200) begin
      tick();
      guard++;
    end
    check("s_reach_3_2", int'(lc_s) * 16 + int'(pc_s), 35);
    reset_small = 1'b1;
    #1;
    check("s_async_pixel", int'(pc_s), 0);
    check("s_async_line", int'(lc_s), 0);
    check("s_async_blank", int'(blank_s), 1);
    tick();
    reset_small = 1'b0;
    tick();
    check("s_restart_fs", int'(fs_s), 1);
    check("s_restart_pixel", int'(pc_s), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
